// File: rtl/dff_bank_arbiter_pkg.sv
// Shared opcode and state definitions for the flip-flop bank arbiter.
package dff_ctrl_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DRIVE  = 2'b01,
    ST_SETTLE = 2'b10
  } state_e;

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester handshake plus flip-flop bank pins; slave = arbiter side, master = requesters/bank side.
interface dff_bank_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  err;
  logic [WIDTH-1:0]      ff_clr_n;
  logic [WIDTH-1:0]      ff_set_n;
  logic [WIDTH-1:0]      ff_d;
  logic [WIDTH-1:0]      ff_q;

  modport slave (
    input  req, op, wdata, ff_q,
    output gnt, done, busy, err, ff_clr_n, ff_set_n, ff_d
  );

  modport master (
    output req, op, wdata, ff_q,
    input  gnt, done, busy, err, ff_clr_n, ff_set_n, ff_d
  );
endinterface

// File: rtl/dff_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr (mod NREQ) wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  logic [PW-1:0] cand_s;

  // Scan ptr+1 .. ptr+NREQ and keep the first active request.
  always_comb begin
    grant  = '0;
    idx    = '0;
    valid  = 1'b0;
    cand_s = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = PW'((int'(ptr) + k) % NREQ);
      if (!valid && req[cand_s]) begin
        valid         = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = cand_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter owning a shared D flip-flop bank; optional readback check under DFF_READBACK_EN.
module dff_bank_arbiter
  import dff_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic          clk,
  input  logic          clr,
  dff_bank_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_r;
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    idx_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [NREQ-1:0]  gnt_r;
  logic [NREQ-1:0]  done_r;
  logic             busy_r;

  logic [NREQ-1:0]  win_grant_s;
  logic [PW-1:0]    win_idx_s;
  logic             win_valid_s;
  logic [1:0]       op_sel_s;
  logic [WIDTH-1:0] data_sel_s;
  logic [WIDTH-1:0] clr_n_s;
  logic [WIDTH-1:0] set_n_s;
  logic [WIDTH-1:0] d_s;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req   (bus.req),
    .ptr   (ptr_r),
    .grant (win_grant_s),
    .idx   (win_idx_s),
    .valid (win_valid_s)
  );

  // Mux the winner's opcode and load data out of the flattened request buses.
  always_comb begin
    op_sel_s   = OP_NOP;
    data_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx_s == PW'(i)) begin
        op_sel_s   = bus.op[2*i +: 2];
        data_sel_s = bus.wdata[WIDTH*i +: WIDTH];
      end else begin
        op_sel_s = op_sel_s;
      end
    end
  end

  // Control FSM with registered grant, done and busy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= ST_IDLE;
      ptr_r   <= PW'(NREQ - 1);
      idx_r   <= '0;
      op_r    <= OP_NOP;
      data_r  <= '0;
      gnt_r   <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= '0;
          if (win_valid_s) begin
            idx_r   <= win_idx_s;
            op_r    <= op_sel_s;
            data_r  <= data_sel_s;
            gnt_r   <= win_grant_s;
            busy_r  <= 1'b1;
            state_r <= ST_DRIVE;
          end else begin
            gnt_r  <= '0;
            busy_r <= 1'b0;
          end
        end
        ST_DRIVE: begin
          done_r  <= gnt_r;
          state_r <= ST_SETTLE;
        end
        ST_SETTLE: begin
          ptr_r   <= idx_r;
          gnt_r   <= '0;
          done_r  <= '0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          gnt_r   <= '0;
          done_r  <= '0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Bank pins: clear while clr is high, drive the latched op in DRIVE, otherwise recirculate Q.
  always_comb begin
    clr_n_s = '1;
    set_n_s = '1;
    d_s     = bus.ff_q;
    if (clr) begin
      clr_n_s = '0;
      d_s     = '0;
    end else if (state_r == ST_DRIVE) begin
      case (op_r)
        OP_LOAD: d_s = data_r;
        OP_SET: begin
          set_n_s = '0;
          d_s     = '1;
        end
        OP_CLR: begin
          clr_n_s = '0;
          d_s     = '0;
        end
        OP_NOP:  d_s = bus.ff_q;
        default: d_s = bus.ff_q;
      endcase
    end else begin
      d_s = bus.ff_q;
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.done     = done_r;
  assign bus.busy     = busy_r;
  assign bus.ff_clr_n = clr_n_s;
  assign bus.ff_set_n = set_n_s;
  assign bus.ff_d     = d_s;

`ifdef DFF_READBACK_EN
  logic [WIDTH-1:0] exp_r;
  logic             err_r;

  function automatic logic [WIDTH-1:0] expected_q(input logic [1:0] opc,
                                                  input logic [WIDTH-1:0] data,
                                                  input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] val;
    val = q;
    case (opc)
      OP_LOAD: val = data;
      OP_SET:  val = '1;
      OP_CLR:  val = '0;
      OP_NOP:  val = q;
      default: val = q;
    endcase
    return val;
  endfunction

  // Capture the expected bank value in DRIVE and compare it against Q in SETTLE; err is sticky.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      exp_r <= '0;
      err_r <= 1'b0;
    end else begin
      if (state_r == ST_DRIVE) begin
        exp_r <= expected_q(op_r, data_r, bus.ff_q);
      end else begin
        exp_r <= exp_r;
      end
      if ((state_r == ST_SETTLE) && (bus.ff_q != exp_r)) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter with a behavioural flip-flop bank model.
module tb_dff_bank_arbiter;
  import dff_ctrl_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct {
    int         who;
    logic [1:0] opc;
    logic [7:0] data;
    logic [7:0] drive_d;
    logic [7:0] exp_q;
  } vec_t;

  logic clk;
  logic clr;
  logic [W-1:0] bank_q;
  logic [W-1:0] stuck_mask;
  int checks;
  int errors;
  vec_t vecs[6];
  logic [7:0] cdata[4];

  dff_bank_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  dff_bank_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: per-bit flop with async active-low clear (priority) and set.
  for (genvar b = 0; b < W; b++) begin : g_bank
    logic q_b;
    always @(posedge clk or negedge bus.ff_clr_n[b] or negedge bus.ff_set_n[b]) begin
      if (!bus.ff_clr_n[b])      q_b <= 1'b0;
      else if (!bus.ff_set_n[b]) q_b <= 1'b1;
      else                       q_b <= bus.ff_d[b];
    end
    assign bank_q[b] = q_b;
  end
  assign bus.ff_q = bank_q & ~stuck_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int who, input logic r, input logic [1:0] o, input logic [7:0] d);
    bus.req   = r ? (bus.req | (4'b0001 << who)) : (bus.req & ~(4'b0001 << who));
    bus.op    = (bus.op & ~(8'h03 << (2*who))) | (8'(o) << (2*who));
    bus.wdata = (bus.wdata & ~(32'h0000_00FF << (8*who))) | (32'(d) << (8*who));
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b1;
    stuck_mask = '0;
    bus.req = '0;
    bus.op = '0;
    bus.wdata = '0;
    vecs[0] = '{2, OP_LOAD, 8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{1, OP_SET,  8'h00, 8'hFF, 8'hFF};
    vecs[2] = '{3, OP_CLR,  8'hFF, 8'h00, 8'h00};
    vecs[3] = '{0, OP_NOP,  8'hC3, 8'h00, 8'h00};
    vecs[4] = '{3, OP_LOAD, 8'h5A, 8'h5A, 8'h5A};
    vecs[5] = '{1, OP_NOP,  8'h99, 8'h5A, 8'h5A};
    cdata = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset held for three cycles
    @(negedge clk);
    check("rst_clr_n", 32'(bus.ff_clr_n), 32'h00);
    check("rst_set_n", 32'(bus.ff_set_n), 32'hFF);
    check("rst_d", 32'(bus.ff_d), 32'h00);
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("post_rst_q", 32'(bus.ff_q), 32'h00);
    check("post_rst_clr_n", 32'(bus.ff_clr_n), 32'hFF);
    check("post_rst_gnt", 32'(bus.gnt), 32'h0);
    check("post_rst_busy", 32'(bus.busy), 32'h0);

    // Single-requester vectors
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      drive(vecs[v].who, 1'b1, vecs[v].opc, vecs[v].data);
      @(negedge clk);
      check($sformatf("v%0d_drive_gnt", v), 32'(bus.gnt), 32'(4'b0001 << vecs[v].who));
      check($sformatf("v%0d_drive_busy", v), 32'(bus.busy), 32'h1);
      check($sformatf("v%0d_drive_done", v), 32'(bus.done), 32'h0);
      check($sformatf("v%0d_drive_d", v), 32'(bus.ff_d), 32'(vecs[v].drive_d));
      check($sformatf("v%0d_drive_set_n", v), 32'(bus.ff_set_n),
            (vecs[v].opc == OP_SET) ? 32'h00 : 32'hFF);
      check($sformatf("v%0d_drive_clr_n", v), 32'(bus.ff_clr_n),
            (vecs[v].opc == OP_CLR) ? 32'h00 : 32'hFF);
      drive(vecs[v].who, 1'b0, ~vecs[v].opc, ~vecs[v].data);
      @(negedge clk);
      check($sformatf("v%0d_settle_done", v), 32'(bus.done), 32'(4'b0001 << vecs[v].who));
      check($sformatf("v%0d_settle_gnt", v), 32'(bus.gnt), 32'(4'b0001 << vecs[v].who));
      @(negedge clk);
      check($sformatf("v%0d_q", v), 32'(bus.ff_q), 32'(vecs[v].exp_q));
      check($sformatf("v%0d_idle_done", v), 32'(bus.done), 32'h0);
      check($sformatf("v%0d_idle_gnt", v), 32'(bus.gnt), 32'h0);
      check($sformatf("v%0d_idle_busy", v), 32'(bus.busy), 32'h0);
      check($sformatf("v%0d_err", v), 32'(bus.err), 32'h0);
    end

    // Bank holds its value while idle
    repeat (10) @(negedge clk);
    check("hold_q", 32'(bus.ff_q), 32'h5A);

    // Reset during DRIVE of a load aborts it; req[0] then wins first
    drive(2, 1'b1, OP_LOAD, 8'h3C);
    @(negedge clk);
    check("abort_drive_gnt", 32'(bus.gnt), 32'h4);
    check("abort_drive_d", 32'(bus.ff_d), 32'h3C);
    clr = 1'b1;
    #1;
    check("abort_gnt", 32'(bus.gnt), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_q", 32'(bus.ff_q), 32'h00);
    bus.req = '0;
    @(negedge clk);
    check("abort_done", 32'(bus.done), 32'h0);
    clr = 1'b0;
    @(negedge clk);
    check("abort_done2", 32'(bus.done), 32'h0);
    check("abort_q2", 32'(bus.ff_q), 32'h00);
    drive(0, 1'b1, OP_LOAD, 8'h81);
    drive(2, 1'b1, OP_LOAD, 8'h3C);
    @(negedge clk);
    check("after_abort_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0100;
    @(negedge clk);
    check("after_abort_done", 32'(bus.done), 32'h1);
    check("after_abort_q", 32'(bus.ff_q), 32'h81);
    bus.req = '0;
    @(negedge clk);
    check("after_abort_busy", 32'(bus.busy), 32'h0);

    // Full contention from reset pointer: order 0,1,2,3,0 every 3 cycles
    pulse_clr();
    for (int i = 0; i < N; i++) drive(i, 1'b1, OP_LOAD, cdata[i]);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk);
        check($sformatf("cont%0d_gap_done", k), 32'(bus.done), 32'h0);
        repeat (2) @(negedge clk);
      end
      check($sformatf("cont%0d_done", k), 32'(bus.done), 32'(4'b0001 << (k % N)));
      check($sformatf("cont%0d_gnt", k), 32'(bus.gnt), 32'(4'b0001 << (k % N)));
      check($sformatf("cont%0d_q", k), 32'(bus.ff_q), 32'(cdata[k % N]));
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("cont_end_busy", 32'(bus.busy), 32'h0);
    check("cont_end_gnt", 32'(bus.gnt), 32'h0);

`ifdef DFF_READBACK_EN
    // Stuck-at-0 on bit 0 during a load of all ones raises sticky err
    stuck_mask = 8'h01;
    drive(1, 1'b1, OP_LOAD, 8'hFF);
    @(negedge clk);
    check("rb_drive_err", 32'(bus.err), 32'h0);
    bus.req = '0;
    @(negedge clk);
    check("rb_settle_err", 32'(bus.err), 32'h0);
    @(negedge clk);
    check("rb_err_set", 32'(bus.err), 32'h1);
    drive(0, 1'b1, OP_LOAD, 8'hFE);
    @(negedge clk);
    bus.req = '0;
    repeat (4) @(negedge clk);
    check("rb_err_sticky", 32'(bus.err), 32'h1);
    pulse_clr();
    check("rb_err_cleared", 32'(bus.err), 32'h0);
    stuck_mask = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Shares one WIDTH-bit bank of D flip-flops among NREQ requesters. Each flip-flop has an active-low clear (priority), an active-low set, and D sampled on clk rise.
- A round-robin grant admits one requester at a time, which may load data, set all bits, clear all bits, or run a no-op.
- The block drives the bank's clr_n/set_n/D pins directly. Between operations it recirculates Q to D so the bank holds its value.
- Sits between requester logic and the flip-flop bank; it is the bank's only writer.

Parameters:
- WIDTH, 8, number of flip-flops in the bank
- NREQ, 4, number of requesters (2..8)

Ports:
- clk  in  1  rising-edge clock shared with the bank
- clr  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level; held until matching done
- op  in  2*NREQ  per-requester opcode, slice i = op[2i+1:2i]; 00 load, 01 set-all, 10 clear-all, 11 nop
- wdata  in  WIDTH*NREQ  per-requester load data, slice i = wdata[WIDTH*i +: WIDTH]
- gnt  out  NREQ  one-hot grant, high during DRIVE and SETTLE
- done  out  NREQ  one-cycle completion pulse to the granted requester
- busy  out  1  high whenever state != IDLE
- ff_clr_n  out  WIDTH  active-low clear to the bank
- ff_set_n  out  WIDTH  active-low set to the bank
- ff_d  out  WIDTH  D inputs to the bank
- ff_q  in  WIDTH  Q outputs from the bank
- err  out  1  readback mismatch flag, sticky; see Optional Feature

Behaviour:
- Reset (clr=1, async):
  - state=IDLE; gnt=0, done=0, busy=0, err=0.
  - ff_set_n all 1. ff_clr_n all 0 for as long as clr is high, so the bank clears during reset. ff_d=0.
  - Round-robin pointer = NREQ-1, so req[0] wins first.
- States: IDLE, DRIVE, SETTLE. Encoding is binary, 2 bits.
- IDLE:
  - Pins: ff_clr_n=all 1, ff_set_n=all 1, ff_d=ff_q (hold).
  - If any req is high: select the first requester at or after pointer+1, modulo NREQ. Latch its index, op and wdata into internal registers, then go to DRIVE. Otherwise stay in IDLE.
- DRIVE (exactly 1 cycle), driven from the latched op/data:
  - load: ff_d=latched wdata; clr_n and set_n all 1.
  - set-all: ff_set_n=all 0; ff_d=all 1.
  - clear-all: ff_clr_n=all 0; ff_d=all 0.
  - nop: ff_d=ff_q; clr_n and set_n all 1.
  - gnt[idx]=1. Next state is SETTLE.
- SETTLE (exactly 1 cycle):
  - Pins return to IDLE hold values; gnt[idx] stays 1; done[idx]=1.
  - Pointer is updated to idx. Next state is IDLE.
- Latency:
  - Request seen in IDLE at edge N: DRIVE in cycle N+1, SETTLE/done in cycle N+2.
  - The bank reflects new data after the edge that ends DRIVE.
  - Throughput is one operation per 3 cycles.
- Requesters:
  - A requester must deassert req in the cycle after done. If req is still high, it is treated as a new request, but it loses to any other pending requester because of rotation.
  - Changes to req, op or wdata after the IDLE capture edge are ignored until the next arbitration.
  - Dropping req during DRIVE or SETTLE does not abort the operation; done still pulses.
- Simultaneous requests: strictly round-robin; no starvation. Worst-case wait is NREQ*3 cycles.
- Reset mid-operation: aborts immediately with no done pulse. The bank is cleared; the pointer returns to NREQ-1.
- done and gnt are registered outputs. ff_* outputs are combinational from state, latched registers and ff_q.

Optional Feature:
- Macro: DFF_READBACK_EN.
- Defined:
  - In DRIVE, capture the expected value: wdata for load, all 1 for set-all, all 0 for clear-all, ff_q for nop.
  - In SETTLE, compare ff_q to the expected value. On mismatch, set err=1. err is sticky until clr.
- Undefined: err is tied to 0, and no expected register or comparator is synthesized.

Decomposition:
- Package dff_ctrl_pkg holds:
  - op encoding constants OP_LOAD=2'b00, OP_SET=2'b01, OP_CLR=2'b10, OP_NOP=2'b11;
  - state constants ST_IDLE, ST_DRIVE, ST_SETTLE.
- One sub-module, rr_arbiter: combinational picker taking req and pointer, returning a one-hot winner and its index. The pointer register stays in the parent.

Test Plan:
- Reset: clr=1 for 3 cycles, then release → ff_clr_n=0 during reset; afterwards ff_q=8'h00, gnt=0, busy=0, err=0.
- Single load: req[2]=1, op=00, wdata slice=8'hA5 → gnt=4'b0100 for 2 cycles; done[2] in cycle N+2; ff_q=8'hA5 and still 8'hA5 ten cycles later.
- Contention: req=4'b1111 with pointer at reset → grant order 0,1,2,3, then 0 again, each done spaced 3 cycles apart.
- Set then clear: req[1] set-all → ff_q=8'hFF; then req[3] clear-all → ff_q=8'h00; nop from req[0] → ff_q unchanged and done[0] pulses.
- Reset mid-op: assert clr during DRIVE of a load of 8'h3C → no done pulse, ff_q=8'h00, next grant goes to req[0].
- Readback (DFF_READBACK_EN): force ff_q bit 0 stuck at 0, then load 8'hFF → err=1 after SETTLE and remains 1 until clr.
